// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA sync generator.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_CLK_DIV   = 2;

  localparam int unsigned COL_W = 11;
  localparam int unsigned ROW_W = 10;

  function automatic int unsigned axis_total(input int unsigned visible, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return visible + front + sync + back;
  endfunction

  function automatic int unsigned h_total(input int unsigned visible, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return axis_total(visible, front, sync, back);
  endfunction

  function automatic int unsigned v_total(input int unsigned visible, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return axis_total(visible, front, sync, back);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus next-state sync/visible decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned FRONT    = DEF_H_FRONT,
  parameter int unsigned SYNC     = DEF_H_SYNC,
  parameter int unsigned BACK     = DEF_H_BACK,
  parameter int unsigned W        = COL_W,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap_c,
  output logic         sync_nxt_c,
  output logic         visible_nxt_c
);

  localparam int unsigned TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam int unsigned SYNC_START = VISIBLE + FRONT;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;

  logic [W-1:0] count_nxt;

  // Decode is taken from the value the counter is about to hold, so the
  // registered flags upstream line up with the registered count.
  always_comb begin
    wrap_c        = inc && (32'(count) == TOTAL - 1);
    count_nxt     = count;
    if (inc) begin
      count_nxt = wrap_c ? '0 : count + W'(1);
    end
    sync_nxt_c    = ((32'(count_nxt) >= SYNC_START) && (32'(count_nxt) < SYNC_END)) ?
                    SYNC_POL : ~SYNC_POL;
    visible_nxt_c = 32'(count_nxt) < VISIBLE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel divider, column/row counters, sync and visible flags.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  output logic [COL_W-1:0] Columnas,
  output logic [ROW_W-1:0] Filas,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             Video_on,
  output logic             Pix_tick,
  output logic             Frame_start
);

  localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if ((H_TOTAL > 2048) || (V_TOTAL > 1024) || (CLK_DIV < 1)) begin : g_param_err
    $error("vga_sync_gen: timing totals exceed counter range or CLK_DIV < 1");
  end

  logic [DIV_W-1:0] div_q;
  logic             h_wrap, v_wrap;
  logic             hs_nxt, vs_nxt, hvis_nxt, vvis_nxt;

  always_comb begin
    Pix_tick = EN && (32'(div_q) == CLK_DIV - 1);
  end

  // Pixel divider; frozen while EN is low so a paused pixel resumes where it stopped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q <= '0;
    end else if (EN) begin
      div_q <= Pix_tick ? '0 : div_q + DIV_W'(1);
    end
  end

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .W       (COL_W),
    .SYNC_POL(SYNC_POL)
  ) u_h (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .inc          (Pix_tick),
    .count        (Columnas),
    .wrap_c       (h_wrap),
    .sync_nxt_c   (hs_nxt),
    .visible_nxt_c(hvis_nxt)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .W       (ROW_W),
    .SYNC_POL(SYNC_POL)
  ) u_v (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .inc          (h_wrap),
    .count        (Filas),
    .wrap_c       (v_wrap),
    .sync_nxt_c   (vs_nxt),
    .visible_nxt_c(vvis_nxt)
  );

  // Flags register next-state decode, giving zero skew against Columnas/Filas.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      HSYNC       <= ~SYNC_POL;
      VSYNC       <= ~SYNC_POL;
      Video_on    <= 1'b0;
      Frame_start <= 1'b0;
    end else begin
      Frame_start <= h_wrap && v_wrap;
      if (EN) begin
        HSYNC    <= hs_nxt;
        VSYNC    <= vs_nxt;
        Video_on <= hvis_nxt && vvis_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: three vga_sync_gen configurations against an arithmetic raster model.
module tb_vga_sync_gen;

  typedef struct {
    int col;
    int row;
    bit hs;
    bit vs;
    bit vid;
    bit pt;
    bit fs;
  } obs_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // def: default timing; fast: CLK_DIV=1, active-high syncs; small: tiny raster, CLK_DIV=3
  logic rst_d = 1'b0, rst_f = 1'b0, rst_s = 1'b0;
  logic en_d = 1'b0, en_f = 1'b0, en_s = 1'b0;
  logic [10:0] col_d, col_f, col_s;
  logic [9:0]  row_d, row_f, row_s;
  logic hs_d, vs_d, vid_d, pt_d, fs_d;
  logic hs_f, vs_f, vid_f, pt_f, fs_f;
  logic hs_s, vs_s, vid_s, pt_s, fs_s;

  vga_sync_gen u_def (
    .CLK(clk), .RST_N(rst_d), .EN(en_d), .Columnas(col_d), .Filas(row_d),
    .HSYNC(hs_d), .VSYNC(vs_d), .Video_on(vid_d), .Pix_tick(pt_d), .Frame_start(fs_d)
  );

  vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_fast (
    .CLK(clk), .RST_N(rst_f), .EN(en_f), .Columnas(col_f), .Filas(row_f),
    .HSYNC(hs_f), .VSYNC(vs_f), .Video_on(vid_f), .Pix_tick(pt_f), .Frame_start(fs_f)
  );

  vga_sync_gen #(
    .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(3), .SYNC_POL(1'b0)
  ) u_small (
    .CLK(clk), .RST_N(rst_s), .EN(en_s), .Columnas(col_s), .Filas(row_s),
    .HSYNC(hs_s), .VSYNC(vs_s), .Video_on(vid_s), .Pix_tick(pt_s), .Frame_start(fs_s)
  );

  // Model state: number of enabled clock edges since reset, and whether the last edge was one.
  longint k_d, k_f, k_s;
  bit st_d, st_f, st_s;

  always @(posedge clk or negedge rst_d)
    if (!rst_d) begin k_d <= 0; st_d <= 1'b0; end
    else begin st_d <= en_d; if (en_d) k_d <= k_d + 1; end

  always @(posedge clk or negedge rst_f)
    if (!rst_f) begin k_f <= 0; st_f <= 1'b0; end
    else begin st_f <= en_f; if (en_f) k_f <= k_f + 1; end

  always @(posedge clk or negedge rst_s)
    if (!rst_s) begin k_s <= 0; st_s <= 1'b0; end
    else begin st_s <= en_s; if (en_s) k_s <= k_s + 1; end

  // Raster position after k enabled edges is simply pixel k/D in row-major order.
  function automatic obs_t model(input longint k, input bit st, input bit en, input int d,
                                 input int hv, input int hf, input int hsy, input int hb,
                                 input int vv, input int vf, input int vsy, input int vb,
                                 input bit pol);
    obs_t e;
    int ht = hv + hf + hsy + hb;
    int vt = vv + vf + vsy + vb;
    longint p = k / d;
    e.col = int'(p % ht);
    e.row = int'((p / ht) % vt);
    e.pt  = en && ((k % d) == longint'(d - 1));
    if (k == 0) begin
      e.hs  = ~pol;
      e.vs  = ~pol;
      e.vid = 1'b0;
      e.fs  = 1'b0;
    end else begin
      e.hs  = (e.col >= hv + hf && e.col < hv + hf + hsy) ? pol : ~pol;
      e.vs  = (e.row >= vv + vf && e.row < vv + vf + vsy) ? pol : ~pol;
      e.vid = (e.col < hv) && (e.row < vv);
      e.fs  = st && ((k % d) == 0) && ((p % (ht * vt)) == 0);
    end
    return e;
  endfunction

  function automatic obs_t pack(input logic [10:0] c, input logic [9:0] r, input logic hs,
                                input logic vs, input logic vid, input logic pt, input logic fs);
    obs_t o;
    o.col = int'(c);
    o.row = int'(r);
    o.hs  = hs;
    o.vs  = vs;
    o.vid = vid;
    o.pt  = pt;
    o.fs  = fs;
    return o;
  endfunction

  task automatic cmp(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check(input string nm, input obs_t g, input obs_t e);
    cmp({nm, ".col"}, g.col, e.col);
    cmp({nm, ".row"}, g.row, e.row);
    cmp({nm, ".hsync"}, int'(g.hs), int'(e.hs));
    cmp({nm, ".vsync"}, int'(g.vs), int'(e.vs));
    cmp({nm, ".video_on"}, int'(g.vid), int'(e.vid));
    cmp({nm, ".pix_tick"}, int'(g.pt), int'(e.pt));
    cmp({nm, ".frame_start"}, int'(g.fs), int'(e.fs));
  endtask

  int fs_cnt_s = 0;
  int fs_last_s = -1;
  int fs_gap_s = 0;

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    cyc++;
    check("def", pack(col_d, row_d, hs_d, vs_d, vid_d, pt_d, fs_d),
          model(k_d, st_d, en_d, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
    check("fast", pack(col_f, row_f, hs_f, vs_f, vid_f, pt_f, fs_f),
          model(k_f, st_f, en_f, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
    check("small", pack(col_s, row_s, hs_s, vs_s, vid_s, pt_s, fs_s),
          model(k_s, st_s, en_s, 3, 10, 2, 3, 2, 6, 2, 2, 3, 1'b0));
    if (fs_s) begin
      if (fs_last_s >= 0) fs_gap_s = cyc - fs_last_s;
      fs_last_s = cyc;
      fs_cnt_s++;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst.def.video_on", int'(vid_d), 0);
    cmp("rst.def.hsync", int'(hs_d), 1);
    cmp("rst.def.vsync", int'(vs_d), 1);
    cmp("rst.def.col", int'(col_d), 0);
    cmp("rst.def.frame_start", int'(fs_d), 0);
    cmp("rst.fast.hsync", int'(hs_f), 0);

    rst_d = 1'b1; rst_f = 1'b1; rst_s = 1'b1;
    en_d = 1'b1; en_f = 1'b1; en_s = 1'b1;

    repeat (656) @(posedge clk);
    #1;
    cmp("k656.fast.col", int'(col_f), 656);
    cmp("k656.fast.hsync", int'(hs_f), 1);
    cmp("k656.def.col", int'(col_d), 328);
    cmp("k656.def.video_on", int'(vid_d), 1);

    repeat (144) @(posedge clk);
    #1;
    cmp("k800.fast.col", int'(col_f), 0);
    cmp("k800.fast.row", int'(row_f), 1);
    cmp("k800.def.col", int'(col_d), 400);

    repeat (512) @(posedge clk);
    #1;
    cmp("k1312.def.col", int'(col_d), 656);
    cmp("k1312.def.hsync", int'(hs_d), 0);
    cmp("k1312.def.video_on", int'(vid_d), 0);

    repeat (288) @(posedge clk);
    #1;
    cmp("k1600.def.col", int'(col_d), 0);
    cmp("k1600.def.row", int'(row_d), 1);
    cmp("k1600.def.hsync", int'(hs_d), 1);
    cmp("k1600.fast.row", int'(row_f), 2);
    cmp("small.frame_count", fs_cnt_s, 2);
    cmp("small.frame_gap", fs_gap_s, 663);

    // Random enable pattern on all three instances.
    repeat (5000) begin
      @(posedge clk);
      #1;
      en_d = ($urandom_range(0, 7) != 0);
      en_f = ($urandom_range(0, 7) != 0);
      en_s = ($urandom_range(0, 3) != 0);
    end

    // Pause the default raster at the start of pixel 300 for 37 clocks.
    en_d = 1'b1;
    n = 0;
    while (!(col_d == 11'd300 && !pt_d) && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmp("wait.col300", int'(n < 4000), 1);
    en_d = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    cmp("gap.col", int'(col_d), 300);
    cmp("gap.pix_tick", int'(pt_d), 0);
    en_d = 1'b1;
    @(posedge clk);
    #1;
    cmp("resume1.col", int'(col_d), 300);
    cmp("resume1.pix_tick", int'(pt_d), 1);
    @(posedge clk);
    #1;
    cmp("resume2.col", int'(col_d), 301);

    // Asynchronous reset of the small raster inside both sync windows.
    en_s = 1'b1;
    n = 0;
    while (!(col_s == 11'd13 && row_s == 10'd9) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmp("wait.small_13_9", int'(n < 2000), 1);
    cmp("pre_rst.small.hsync", int'(hs_s), 0);
    cmp("pre_rst.small.vsync", int'(vs_s), 0);
    rst_s = 1'b0;
    #1;
    cmp("async_rst.small.col", int'(col_s), 0);
    cmp("async_rst.small.row", int'(row_s), 0);
    cmp("async_rst.small.hsync", int'(hs_s), 1);
    cmp("async_rst.small.vsync", int'(vs_s), 1);
    cmp("async_rst.small.video_on", int'(vid_s), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_s = 1'b1;
    @(posedge clk);
    #1;
    cmp("release.small.video_on", int'(vid_s), 1);
    cmp("release.small.col", int'(col_s), 0);
    cmp("release.small.frame_start", int'(fs_s), 0);

    repeat (1500) begin
      @(posedge clk);
      #1;
      en_d = ($urandom_range(0, 1) != 0);
      en_f = ($urandom_range(0, 1) != 0);
      en_s = ($urandom_range(0, 4) != 0);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator directly upstream of the character ROM stage.
- Produces the Columnas/Filas pixel coordinates that stage addresses from, plus HSYNC/VSYNC, the visible-area flag and a frame-start strobe.
- Default timing is 640x480@60 Hz from a 50 MHz system clock: one pixel every 2 clocks.
- Coordinates are held stable for CLK_DIV clocks, so the downstream synchronous ROM read settles within the pixel.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1)
- SYNC_POL, 0, active level of HSYNC/VSYNC (0 = active-low)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  run enable; low freezes all state
- Columnas  out  11  current column, 0..H_TOTAL-1
- Filas  out  10  current row, 0..V_TOTAL-1
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- Video_on  out  1  high while the current pixel is visible
- Pix_tick  out  1  one-CLK pulse marking the last clock of the current pixel
- Frame_start  out  1  one-CLK pulse when the counters enter (0,0)

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Elaboration error if H_TOTAL > 2048, V_TOTAL > 1024 or CLK_DIV < 1.
- Reset, asynchronous:
  - divider = 0, Columnas = 0, Filas = 0
  - HSYNC = VSYNC = ~SYNC_POL (inactive)
  - Video_on = 0, Pix_tick = 0, Frame_start = 0
- Divider counts 0..CLK_DIV-1 while EN=1. Pix_tick is combinational: EN && divider == CLK_DIV-1. With CLK_DIV=1, Pix_tick = EN.
- On a clock edge with Pix_tick=1:
  - Columnas increments.
  - At H_TOTAL-1 Columnas wraps to 0 and Filas increments.
  - Filas at V_TOTAL-1, on that same column wrap, wraps to 0.
- Columnas/Filas are registers and change only on Pix_tick edges, so each value is held exactly CLK_DIV clocks.
- HSYNC, VSYNC and Video_on are registered, decoded from the next-state counter values. They therefore always describe the same pixel as the Columnas/Filas outputs: zero relative skew, no extra latency.
  - HSYNC = SYNC_POL when H_VISIBLE+H_FRONT <= col <= H_VISIBLE+H_FRONT+H_SYNC-1 (656..751), else ~SYNC_POL.
  - VSYNC = SYNC_POL when V_VISIBLE+V_FRONT <= row <= V_VISIBLE+V_FRONT+V_SYNC-1 (490..491), else ~SYNC_POL.
  - Video_on = (col < H_VISIBLE) && (row < V_VISIBLE).
- Frame_start is registered and high for exactly one CLK: the edge on which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). It is not asserted on reset release.
- EN=0: divider, counters, HSYNC, VSYNC and Video_on hold; Pix_tick = 0; Frame_start = 0. Resuming continues from the held state with no skipped or repeated pixel.
- First edge after reset release with EN=1: decode outputs load the values for (0,0), i.e. Video_on becomes 1.
- RST_N asserted mid-line or mid-frame: immediate return to reset values regardless of CLK.
- Downstream consumers that use synchronous ROMs must add their own pipeline compensation; this block has no knowledge of it.

Decomposition:
- Shared package vga_timing_pkg holds:
  - default timing constants
  - H_TOTAL/V_TOTAL computation functions
  - coordinate width constants: COL_W = 11, ROW_W = 10
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical).
  - Parameters: VISIBLE, FRONT, SYNC, BACK, W, SYNC_POL.
  - Inputs: CLK, RST_N, inc.
  - Outputs: count, wrap (combinational, count == TOTAL-1 && inc), next-state sync, next-state visible.
  - Horizontal inc = Pix_tick; vertical inc = horizontal wrap.
- The top holds the divider, Frame_start and the output registers.

Test Plan:
- Reset, then release with EN=1 -> all outputs at reset values during reset; after release Video_on=1, Columnas=0, Filas=0, Pix_tick high on every 2nd CLK.
- Run one line -> Columnas steps 0..799, each value held 2 CLK; after 1600 CLK Columnas=0 and Filas=1. HSYNC low from col 656 to col 751 inclusive (192 CLK); Video_on low from col 640 onward.
- Run one full frame -> VSYNC low for rows 490-491 (3200 CLK); Video_on never high for row >= 480. Frame_start is a single 1-CLK pulse, spaced 840000 CLK apart, coincident with (0,0).
- EN low for 37 CLK at Columnas=300 mid-pixel, then high -> counters and syncs frozen and Pix_tick=0 during the gap; pixel 300 then completes its remaining clocks and advances to 301; no pixel skipped.
- RST_N pulsed low at (Columnas=700, Filas=491) -> asynchronous return to (0,0); HSYNC=VSYNC=1 and Video_on=0 during reset; no Frame_start pulse on release.
- Re-parameterise with CLK_DIV=1, SYNC_POL=1 -> Columnas advances every CLK; HSYNC and VSYNC are high during their sync windows; line period is 800 CLK.
